// File: rtl/temp_display_driver.sv
// temp_display_driver
//   Converts the thermostat's binary setpoint and measured temperature to BCD
//   with a sequential shift-add-3 engine once per refresh tick. It also scans
//   the committed digits onto a 4-digit common-anode 7-segment display.
//
//   Optional feature macro: LEADING_ZERO_BLANK_EN (blank a tens digit of 0).
//
//   Ports:
//     clk          system clock
//     Reset        asynchronous active-high reset
//     CurrentTemp  measured temperature, unsigned binary (0..99 valid)
//     ChangedTemp  setpoint temperature, unsigned binary (0..99 valid)
//     an[3:0]      digit enables, active-low (0/1 = current ones/tens, 2/3 = setpoint ones/tens)
//     seg[6:0]     segments a..g, active-low
//     dp           decimal point, active-low (lit on digit 2 while setpoint != current)
//     busy         high while a conversion is in flight
module temp_display_driver #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic [7:0] CurrentTemp,
    input  logic [7:0] ChangedTemp,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       busy
);

    localparam int unsigned CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [3:0] DIG_BLANK = 4'd10;
    localparam logic [3:0] DIG_DASH  = 4'd11;

    typedef enum logic [2:0] {IDLE, CAPTURE, CONV_A, CONV_B, COMMIT} state_t;

    // Active-low segment pattern, g..a order
    function automatic logic [6:0] seg_code(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:     s = 7'b1000000;
            4'd1:     s = 7'b1111001;
            4'd2:     s = 7'b0100100;
            4'd3:     s = 7'b0110000;
            4'd4:     s = 7'b0011001;
            4'd5:     s = 7'b0010010;
            4'd6:     s = 7'b0000010;
            4'd7:     s = 7'b1111000;
            4'd8:     s = 7'b0000000;
            4'd9:     s = 7'b0010000;
            DIG_DASH: s = 7'b0111111;
            default:  s = 7'b1111111;
        endcase
        return s;
    endfunction

    // One shift-add-3 iteration: correct nibbles >= 5, then shift the next bit in.
    // Hundreds are dropped; values above 99 are dashed and never use the BCD result.
    function automatic logic [7:0] bcd_step(input logic [7:0] bcd, input logic bit_in);
        logic [7:0] adj;
        adj = bcd;
        if (adj[3:0] >= 4'd5) adj[3:0] = adj[3:0] + 4'd3;
        if (adj[7:4] >= 4'd5) adj[7:4] = adj[7:4] + 4'd3;
        return 8'({adj, bit_in});
    endfunction

    // Digit pair {tens, ones} to commit for one temperature
    function automatic logic [7:0] pair_digits(input logic [7:0] val, input logic [7:0] bcd);
        logic [3:0] tens;
        logic [3:0] ones;
        if (val > 8'd99) begin
            tens = DIG_DASH;
            ones = DIG_DASH;
        end else begin
            tens = bcd[7:4];
            ones = bcd[3:0];
`ifdef LEADING_ZERO_BLANK_EN
            if (tens == 4'd0) tens = DIG_BLANK;
`endif
        end
        return {tens, ones};
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tick_q, tick_d;
    logic [1:0]       scan_idx_q, scan_idx_d;
    logic [1:0]       sel_q, sel_d;
    logic             active_q, active_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       sh_q, sh_d;
    logic [7:0]       bcd_q, bcd_d;
    logic [7:0]       cur_snap_q, cur_snap_d;
    logic [7:0]       chg_snap_q, chg_snap_d;
    logic [7:0]       cur_bcd_q, cur_bcd_d;
    logic [15:0]      dig_q, dig_d;      // {sp tens, sp ones, cur tens, cur ones}
    logic             dp_flag_q, dp_flag_d;
    logic [3:0]       an_q, an_d;
    logic [6:0]       seg_q, seg_d;
    logic             dp_q, dp_d;
    logic             busy_q, busy_d;

    // Next-state logic for counter, scanner, conversion FSM and outputs
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q + CNT_W'(1);
        tick_d     = 1'b0;
        scan_idx_d = scan_idx_q;
        sel_d      = sel_q;
        active_d   = active_q;
        bit_cnt_d  = bit_cnt_q;
        sh_d       = sh_q;
        bcd_d      = bcd_q;
        cur_snap_d = cur_snap_q;
        chg_snap_d = chg_snap_q;
        cur_bcd_d  = cur_bcd_q;
        dig_d      = dig_q;
        dp_flag_d  = dp_flag_q;

        // Tick is registered, so it is high in the cycle after the wrap
        if (cnt_q == CNT_W'(REFRESH_DIV - 1)) begin
            cnt_d  = '0;
            tick_d = 1'b1;
        end

        if (tick_q) begin
            sel_d      = scan_idx_q;
            scan_idx_d = scan_idx_q + 2'd1;
            active_d   = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tick_q) state_d = CAPTURE;
            end
            CAPTURE: begin
                cur_snap_d = CurrentTemp;
                chg_snap_d = ChangedTemp;
                sh_d       = CurrentTemp;
                bcd_d      = '0;
                bit_cnt_d  = '0;
                state_d    = CONV_A;
            end
            CONV_A: begin
                bcd_d     = bcd_step(bcd_q, sh_q[7]);
                sh_d      = {sh_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    // Park the current result and reuse the shifter for the setpoint
                    cur_bcd_d = bcd_d;
                    sh_d      = chg_snap_q;
                    bcd_d     = '0;
                    state_d   = CONV_B;
                end
            end
            CONV_B: begin
                bcd_d     = bcd_step(bcd_q, sh_q[7]);
                sh_d      = {sh_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) state_d = COMMIT;
            end
            COMMIT: begin
                dig_d     = {pair_digits(chg_snap_q, bcd_q), pair_digits(cur_snap_q, cur_bcd_q)};
                dp_flag_d = (chg_snap_q != cur_snap_q);
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);

        // Outputs follow next-state values so a commit is visible one cycle later
        an_d  = active_d ? ~(4'b0001 << sel_d) : 4'b1111;
        seg_d = active_d ? seg_code(dig_d[{sel_d, 2'b00} +: 4]) : 7'b1111111;
        dp_d  = !(active_d && (sel_d == 2'd2) && dp_flag_d);
    end

    // State register
    always_ff @(posedge clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tick_q     <= 1'b0;
            scan_idx_q <= '0;
            sel_q      <= '0;
            active_q   <= 1'b0;
            bit_cnt_q  <= '0;
            sh_q       <= '0;
            bcd_q      <= '0;
            cur_snap_q <= '0;
            chg_snap_q <= '0;
            cur_bcd_q  <= '0;
            dig_q      <= '0;
            dp_flag_q  <= 1'b0;
            an_q       <= 4'b1111;
            seg_q      <= 7'b1111111;
            dp_q       <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            scan_idx_q <= scan_idx_d;
            sel_q      <= sel_d;
            active_q   <= active_d;
            bit_cnt_q  <= bit_cnt_d;
            sh_q       <= sh_d;
            bcd_q      <= bcd_d;
            cur_snap_q <= cur_snap_d;
            chg_snap_q <= chg_snap_d;
            cur_bcd_q  <= cur_bcd_d;
            dig_q      <= dig_d;
            dp_flag_q  <= dp_flag_d;
            an_q       <= an_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            busy_q     <= busy_d;
        end
    end

    assign an   = an_q;
    assign seg  = seg_q;
    assign dp   = dp_q;
    assign busy = busy_q;

endmodule
